// File: rtl/lut_arbiter.sv
// lut_arbiter: round-robin arbiter granting NR_REQ requesters access to a small
// key/data lookup table that a configuration port can rewrite between lookups.
module lut_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 8,
  parameter int DATA_LEN = 8,
  localparam int RW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
  localparam int IW = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NR_REQ-1:0]           req_valid,
  input  logic [NR_REQ*KEY_LEN-1:0]   req_key,
  output logic [NR_REQ-1:0]           req_ready,
  output logic [NR_REQ-1:0]           rsp_valid,
  input  logic [NR_REQ-1:0]           rsp_ready,
  output logic [DATA_LEN-1:0]         rsp_data,
  output logic                        rsp_hit,
  input  logic [DATA_LEN-1:0]         default_out,
  input  logic                        cfg_we,
  input  logic [IW-1:0]               cfg_idx,
  input  logic [KEY_LEN-1:0]          cfg_key,
  input  logic [DATA_LEN-1:0]         cfg_data,
  output logic                        cfg_ready
);
  typedef enum logic [1:0] {IDLE, LOOK, RESP} state_e;
  state_e state_q, state_d;
  logic [RW-1:0] rr_ptr_q, id_q, gnt_id, cand;
  logic gnt_any, accept, hit;
  logic [KEY_LEN-1:0] key_q;
  logic [KEY_LEN-1:0] tbl_key_q [NR_KEY];
  logic [DATA_LEN-1:0] tbl_data_q [NR_KEY];
  logic [NR_KEY-1:0] tbl_vld_q;
  logic [DATA_LEN-1:0] rsp_data_q, hit_data;
  logic rsp_hit_q;
  // Scan downward so the closest requester after rr_ptr is the last to assign.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int i = NR_REQ; i >= 1; i--) begin
      cand = RW'((int'(rr_ptr_q) + i) % NR_REQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign req_ready = (state_q == IDLE && !cfg_we && gnt_any) ? NR_REQ'(1) << gnt_id : '0;
  assign accept = |(req_valid & req_ready);
  assign cfg_ready = (state_q == IDLE) && cfg_we;
  assign rsp_valid = (state_q == RESP) ? NR_REQ'(1) << id_q : '0;
  assign rsp_data = rsp_data_q;
  assign rsp_hit = rsp_hit_q;
  // Lowest-index matching entry wins, again by scanning downward.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int k = NR_KEY - 1; k >= 0; k--) begin
      if (tbl_vld_q[k] && tbl_key_q[k] == key_q) begin
        hit = 1'b1;
        hit_data = tbl_data_q[k];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = LOOK;
    else if (state_q == LOOK) state_d = RESP;
    else if (state_q == RESP && rsp_ready[id_q]) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= RW'(NR_REQ - 1);
      id_q <= '0;
      key_q <= '0;
      rsp_data_q <= '0;
      rsp_hit_q <= 1'b0;
      tbl_vld_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr_q <= gnt_id;
        id_q <= gnt_id;
        key_q <= req_key[int'(gnt_id)*KEY_LEN +: KEY_LEN];
      end
      if (state_q == LOOK) begin
        rsp_hit_q <= hit;
        rsp_data_q <= hit ? hit_data : default_out;
      end
      for (int k = 0; k < NR_KEY; k++)
        if (cfg_ready && int'(cfg_idx) == k) tbl_vld_q[k] <= 1'b1;
    end
  end
  // Key/data storage needs no reset: the valid bits gate every match.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NR_KEY; k++) begin
      if (cfg_ready && int'(cfg_idx) == k) begin
        tbl_key_q[k] <= cfg_key;
        tbl_data_q[k] <= cfg_data;
      end
    end
  end
endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter: scenario tasks plus randomized traffic checked against a
// behavioural table/round-robin model.
module tb_lut_arbiter;
  logic clk = 1'b0, rst_n;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_key;
  logic [7:0] rsp_data, deflt, cfg_key, cfg_data;
  logic rsp_hit, cfg_we, cfg_ready;
  logic [1:0] cfg_idx;
  int errs = 0, checks = 0;
  logic [7:0] m_key [4];
  logic [7:0] m_data [4];
  logic m_vld [4];
  int m_ptr;

  lut_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_key(req_key),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .default_out(deflt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready)
  );

  always #5 clk = ~clk;

  function automatic int model_arb(input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) if (mask[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [8:0] model_lookup(input logic [7:0] key);
    for (int k = 0; k < 4; k++) if (m_vld[k] && m_key[k] == key) return {1'b1, m_data[k]};
    return {1'b0, deflt};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_vld[k] = 1'b0;
    m_ptr = 3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; cfg_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int idx, input logic [7:0] key, input logic [7:0] data, output logic rdy);
    int n;
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_key = key; cfg_data = data;
    #1;
    n = 0;
    while (!cfg_ready && n < 20) begin @(negedge clk); #1; n++; end
    rdy = cfg_ready;
    if (rdy && idx < 4) begin m_key[idx] = key; m_data[idx] = data; m_vld[idx] = 1'b1; end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_lookup(input logic [3:0] mask, input logic [31:0] keys, input int hold,
                            output int win, output logic [3:0] look_v, output logic [3:0] resp_v,
                            output logic hit, output logic [7:0] data, output logic stable);
    int n;
    @(negedge clk);
    req_valid = mask; req_key = keys;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin @(negedge clk); #1; n++; end
    win = -1;
    for (int i = 0; i < 4; i++) if (req_ready[i]) win = i;
    look_v = '0; resp_v = '0; hit = 1'b0; data = '0; stable = 1'b0;
    if (win < 0) begin req_valid = '0; return; end
    @(negedge clk);
    req_valid = '0;
    look_v = rsp_valid;
    @(negedge clk);
    resp_v = rsp_valid; hit = rsp_hit; data = rsp_data; stable = 1'b1;
    rsp_ready = ~(4'b1 << win);
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== resp_v || rsp_hit !== hit || rsp_data !== data) stable = 1'b0;
    end
    rsp_ready = 4'b1 << win;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0001; req_key = '0; rsp_ready = '0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_key = '0; cfg_data = '0; deflt = '0;
    model_reset();
    #1;
    checks++; if (rsp_valid !== 4'b0) begin errs++; $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errs++; $display("FAIL rst_rsp_data got %h want 00", rsp_data); end
    checks++; if (rsp_hit !== 1'b0) begin errs++; $display("FAIL rst_rsp_hit got %b want 0", rsp_hit); end
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL rst_req_ready got %b want 0001", req_ready); end
    checks++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); end
    cfg_we = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b1 || req_ready !== 4'b0) begin errs++; $display("FAIL rst_cfg_prio got cfg_ready=%b req_ready=%b want 1/0000", cfg_ready, req_ready); end
    cfg_we = 1'b0; req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_lookup();
    int win; logic [3:0] lv, rv; logic h, st; logic [7:0] d;
    deflt = 8'hEE;
    run_lookup(4'b0001, {4{8'h1C}}, 0, win, lv, rv, h, d, st);
    m_ptr = 0;
    checks++; if (win !== 0) begin errs++; $display("FAIL rl_winner got %0d want 0", win); end
    checks++; if (lv !== 4'b0) begin errs++; $display("FAIL rl_look_valid got %b want 0000", lv); end
    checks++; if (rv !== 4'b0001) begin errs++; $display("FAIL rl_rsp_valid got %b want 0001", rv); end
    checks++; if (h !== 1'b0 || d !== 8'hEE) begin errs++; $display("FAIL rl_miss got hit=%b data=%h want 0/ee", h, d); end
  endtask

  task automatic test_config_hit();
    int win, exp; logic [3:0] lv, rv; logic h, st, rdy; logic [7:0] d; logic [8:0] m;
    cfg_write(2, 8'h1C, 8'h61, rdy);
    checks++; if (rdy !== 1'b1) begin errs++; $display("FAIL ch_cfg_ready got %b want 1", rdy); end
    exp = model_arb(4'b1000); m = model_lookup(8'h1C);
    run_lookup(4'b1000, {4{8'h1C}}, 1, win, lv, rv, h, d, st);
    m_ptr = exp;
    checks++; if (rv !== 4'b1000) begin errs++; $display("FAIL ch_rsp_valid got %b want 1000", rv); end
    checks++; if ({h, d} !== m) begin errs++; $display("FAIL ch_hit got %b/%h want %b/%h", h, d, m[8], m[7:0]); end
    cfg_write(0, 8'h1C, 8'h41, rdy);
    exp = model_arb(4'b0010); m = model_lookup(8'h1C);
    run_lookup(4'b0010, {4{8'h1C}}, 0, win, lv, rv, h, d, st);
    m_ptr = exp;
    checks++; if (win !== exp) begin errs++; $display("FAIL ch_dup_winner got %0d want %0d", win, exp); end
    checks++; if ({h, d} !== m || d !== 8'h41) begin errs++; $display("FAIL ch_dup_data got %b/%h want 1/41", h, d); end
  endtask

  task automatic test_round_robin();
    int got, exp, last, n, cyc;
    do_reset();
    @(negedge clk);
    req_valid = 4'b1111; req_key = 32'h44332211; rsp_ready = 4'b1111;
    n = 0; cyc = 0; last = -3;
    while (n < 5 && cyc < 40) begin
      #1;
      if (req_ready != 4'b0) begin
        got = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) got = i;
        exp = model_arb(4'b1111);
        checks++; if (got !== exp || $countones(req_ready) != 1) begin errs++; $display("FAIL rr_grant%0d got %b want id %0d", n, req_ready, exp); end
        checks++; if (n > 0 && cyc - last != 3) begin errs++; $display("FAIL rr_spacing%0d got %0d want 3", n, cyc - last); end
        m_ptr = exp; last = cyc; n++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n != 5) begin errs++; $display("FAIL rr_count got %0d want 5", n); end
    req_valid = '0;
    repeat (3) @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_cfg_priority();
    logic rdy;
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_key = 8'h5A; cfg_data = 8'hA5; req_valid = 4'b0010;
    #1;
    checks++; if (cfg_ready !== 1'b1 || req_ready !== 4'b0000) begin errs++; $display("FAIL cp_same_cycle got cfg_ready=%b req_ready=%b want 1/0000", cfg_ready, req_ready); end
    m_key[3] = 8'h5A; m_data[3] = 8'hA5; m_vld[3] = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL cp_next_grant got %b want 0010", req_ready); end
    m_ptr = 1;
    rdy = 1'b0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if ({rsp_hit, rsp_data} !== {1'b0, deflt}) begin errs++; $display("FAIL cp_lookup got %b/%h want 0/%h", rsp_hit, rsp_data, deflt); end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    int n, win, exp; logic [3:0] lv, rv; logic h, st, rdy; logic [7:0] d; logic [7:0] dsave;
    cfg_write(1, 8'h33, 8'h77, rdy);
    deflt = 8'h99;
    @(negedge clk);
    req_valid = 4'b0100; req_key = 32'h00330000;
    #1;
    n = 0;
    while (!req_ready[2] && n < 20) begin @(negedge clk); #1; n++; end
    m_ptr = 2;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    dsave = rsp_data;
    checks++; if (rsp_valid !== 4'b0100 || rsp_hit !== 1'b1 || rsp_data !== 8'h77) begin errs++; $display("FAIL bp_resp got v=%b hit=%b data=%h want 0100/1/77", rsp_valid, rsp_hit, rsp_data); end
    rsp_ready = 4'b1011;
    st = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0100 || rsp_data !== dsave || rsp_hit !== 1'b1) st = 1'b0;
    end
    checks++; if (st !== 1'b1) begin errs++; $display("FAIL bp_stable got %b want 1", st); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0 || rsp_data !== 8'h00 || rsp_hit !== 1'b0) begin errs++; $display("FAIL bp_async_rst got v=%b data=%h hit=%b want 0000/00/0", rsp_valid, rsp_data, rsp_hit); end
    rsp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp = model_arb(4'b0100);
    run_lookup(4'b0100, 32'h00330000, 0, win, lv, rv, h, d, st);
    m_ptr = exp;
    checks++; if (win !== exp || h !== 1'b0 || d !== 8'h99) begin errs++; $display("FAIL bp_cleared got win=%0d hit=%b data=%h want %0d/0/99", win, h, d, exp); end
  endtask

  task automatic test_random();
    int win, exp, hold; logic [3:0] lv, rv, mask; logic h, st, rdy; logic [7:0] d; logic [31:0] keys; logic [8:0] m;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write($urandom_range(0, 3), 8'h10 + 8'($urandom_range(0, 3)), 8'($urandom), rdy);
        checks++; if (rdy !== 1'b1) begin errs++; $display("FAIL rnd_cfg%0d got %b want 1", it, rdy); end
      end else begin
        mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) keys[i*8 +: 8] = 8'h10 + 8'($urandom_range(0, 7));
        deflt = 8'($urandom);
        hold = $urandom_range(0, 3);
        exp = model_arb(mask);
        m = model_lookup(keys[exp*8 +: 8]);
        run_lookup(mask, keys, hold, win, lv, rv, h, d, st);
        m_ptr = exp;
        checks++; if (win !== exp) begin errs++; $display("FAIL rnd_win%0d got %0d want %0d mask %b", it, win, exp, mask); end
        checks++; if (lv !== 4'b0 || rv !== 4'(1 << exp)) begin errs++; $display("FAIL rnd_valid%0d got look=%b resp=%b want 0000/%b", it, lv, rv, 4'(1 << exp)); end
        checks++; if ({h, d} !== m || st !== 1'b1) begin errs++; $display("FAIL rnd_data%0d got %b/%h stable=%b want %b/%h", it, h, d, st, m[8], m[7:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_lookup();
    test_config_hit();
    test_round_robin();
    test_cfg_priority();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
